// File: rtl/tconvert.sv
// Two-stage pipelined Celsius to display-units converter.
// Result is tenths of a degree: tc*10 (Celsius) or tc*18 + 320 (Fahrenheit).
module tconvert #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    c_f,
    input  logic signed [IN_W-1:0]  tc,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] tx10
);

    if (OUT_W < IN_W + 5) begin : g_width_check
        $error("tconvert: OUT_W must be at least IN_W+5");
    end

    logic signed [OUT_W-1:0] tc_ext;
    logic signed [OUT_W-1:0] prod;
    logic signed [OUT_W-1:0] prod_q;
    logic signed [OUT_W-1:0] offset;
    logic                    c_f_q;
    logic                    valid_q;

    assign tc_ext = {{(OUT_W-IN_W){tc[IN_W-1]}}, tc};

    // x18 = x<<4 + x<<1, x10 = x<<3 + x<<1
    always_comb begin
        prod = '0;
        if (c_f) begin
            prod = (tc_ext <<< 4) + (tc_ext <<< 1);
        end else begin
            prod = (tc_ext <<< 3) + (tc_ext <<< 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            c_f_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= prod;
                c_f_q  <= c_f;
            end
        end
    end

    assign offset = c_f_q ? OUT_W'(320) : '0;

    // tx10 holds its last result through idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx10      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_q;
            if (valid_q) begin
                tx10 <= prod_q + offset;
            end
        end
    end

endmodule

// File: tb/tb_tconvert.sv
// Scoreboard bench for tconvert: directed vectors queue expected results with
// their due cycle; an independent monitor checks value, timing and hold.
module tb_tconvert;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               c_f;
    logic signed [12:0] tc;
    logic               out_valid;
    logic signed [17:0] tx10;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   last_exp = 0;

    tconvert #(.IN_W(13), .OUT_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .c_f       (c_f),
        .tc        (tc),
        .out_valid (out_valid),
        .tx10      (tx10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic cf, input int t, input int exp);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        c_f      = cf;
        tc       = 13'(t);
        e.due    = cyc + 2;
        e.val    = exp;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            c_f      = 1'($urandom_range(0, 1));
            tc       = 13'($urandom);
        end
    endtask

    // Monitor: checks every cycle shortly after the rising edge
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("latency", cyc, e.due);
                    check("tx10", int'(tx10), e.val);
                    last_exp = e.val;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    check("missing_out_valid", 0, 1);
                end
                check("tx10_hold", int'(tx10), last_exp);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        c_f      = 1'b0;
        tc       = '0;
        repeat (3) @(negedge clk);
        check("reset_tx10", int'(tx10), 0);
        check("reset_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        idle(2);

        // Celsius back-to-back
        send(1'b0, 50, 500);
        send(1'b0, 30, 300);
        idle(2);

        // Fahrenheit
        send(1'b1, 100, 2120);
        send(1'b1, 0, 320);
        send(1'b1, -10, 140);
        send(1'b1, -40, -400);
        send(1'b0, -40, -400);
        send(1'b0, -1, -10);
        send(1'b1, 1, 338);
        idle(2);

        // Extremes
        send(1'b1, -4096, -73408);
        send(1'b1, 4095, 74030);
        send(1'b0, -4096, -40960);
        send(1'b0, 4095, 40950);
        idle(2);

        // Interleaved units
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2), 37, (i % 2) ? 986 : 370);
        end

        // Gaps
        send(1'b0, 12, 120);
        idle(1);
        send(1'b1, 5, 410);
        idle(3);
        send(1'b0, -7, -70);
        idle(2);
        send(1'b1, 20, 680);
        idle(4);

        // Asynchronous reset with a conversion in flight
        send(1'b1, 123, 2534);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        q.delete();
        last_exp = 0;
        #1;
        check("async_reset_tx10", int'(tx10), 0);
        check("async_reset_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);

        send(1'b0, 7, 70);
        idle(3);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            check("drain_timeout", q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
